fft_frame_sequencer: RTL and testbench
======================================

Name: fft_frame_sequencer

Overview:
- Sequences one complete FFT transform per start pulse.
- Pushes one configuration beat to the FFT core's config stream, gates exactly NFFT input samples from the sample source into the core's data stream with TLAST on the last one, then waits for the core's output frame to finish before signalling done.
- Sits between the register interface (scale schedule, direction, start) and the FFT core's config, data-in and data-out AXI-Stream channels.

Parameters:
- LOG2_NFFT, 4, log2 of transform length; NFFT = 2**LOG2_NFFT samples per frame.
- DATA_WIDTH, 32, sample width in bits (packed complex) on the input passthrough.

Ports:
- clk  input  1  clock
- resetn  input  1  asynchronous active-low reset
- start  input  1  single-cycle request to run one frame
- scaleSch  input  4  scaling schedule, sampled on accepted start
- forward  input  1  1 = forward FFT, 0 = inverse; sampled on accepted start
- busy  output  1  high from accepted start until done pulse (inclusive)
- done  output  1  one-cycle pulse when the output frame completes
- cfg_tready  input  1  FFT config channel ready
- cfg_tvalid  output  1  FFT config channel valid
- cfg_tdata  output  8  config word
- s_tvalid  input  1  sample source valid
- s_tready  output  1  sample source ready
- s_tdata  input  DATA_WIDTH  sample source data
- d_tvalid  output  1  FFT data-in valid
- d_tready  input  1  FFT data-in ready
- d_tdata  output  DATA_WIDTH  FFT data-in data
- d_tlast  output  1  FFT data-in last
- o_beat  input  1  FFT output-channel handshake (tvalid and tready) observed
- o_last  input  1  FFT output-channel tlast, qualified by o_beat

Behaviour:
- Reset (resetn low, asynchronous): state = IDLE; busy, done, cfg_tvalid and d_tvalid-gating all 0; cfg_tdata = 0; sample counter = 0.
  - A reset mid-frame aborts immediately.
  - No partial transaction is completed; the FFT core is reset by the same reset.
- States: IDLE, CONFIG, STREAM, DRAIN, DONE.
- IDLE:
  - start = 1 → latch {scaleSch, forward} into a register and go to CONFIG next cycle.
  - start in any other state is ignored (no queueing).
- CONFIG:
  - cfg_tvalid = 1 and cfg_tdata = {3'b0, scaleSch_latched, forward_latched}, both registered and stable until the handshake.
  - On cfg_tvalid & cfg_tready → cfg_tvalid drops next cycle and state moves to STREAM.
  - A single config beat is sent per frame; there is no TLAST on the config channel.
- STREAM, combinational passthrough with zero latency:
  - d_tvalid = s_tvalid, s_tready = d_tready, d_tdata = s_tdata.
  - Counter increments on each d_tvalid & d_tready.
  - d_tlast = 1 when the counter equals NFFT-1.
  - The handshake at count NFFT-1 → counter clears to 0 and state moves to DRAIN.
  - Outside STREAM: s_tready = 0, d_tvalid = 0, d_tlast = 0.
- DRAIN:
  - Wait for o_beat & o_last, then go to DONE.
  - Output beats without o_last are ignored.
  - An o_last arriving during STREAM (previous frame residue) is ignored.
- DONE: done = 1 for exactly one cycle, then return to IDLE. busy is still 1 in this cycle and 0 in the next.
- busy = (state != IDLE).
- Back-to-back operation: the earliest re-start is a start asserted in the first IDLE cycle after DONE.
- Stalls:
  - cfg_tready low holds CONFIG indefinitely.
  - s_tvalid or d_tready low holds the counter.
  - There is no timeout.
- Counter is LOG2_NFFT bits wide and wraps naturally at NFFT-1 → 0.
- Minimum frame latency from start to done, with all ready signals constantly high, the output arriving immediately and o_last asserted on the first o_beat: 1 (IDLE→CONFIG) + 1 (config beat) + NFFT (samples) + 1 (DRAIN) + 1 (DONE) cycles.

Test Plan:
- Config beat, no stall: reset, then start with scaleSch=4'b1010, forward=1 and cfg_tready=1 → exactly one cfg beat with cfg_tdata=8'h15; busy rises the cycle after start.
- Config stall: cfg_tready held 0 for 5 cycles → cfg_tvalid stays 1 and cfg_tdata stays stable for those 5 cycles; no s_tready before the config handshake.
- Frame length and TLAST: LOG2_NFFT=4, 16 samples with s_tvalid random 50% and d_tready random → exactly 16 d-channel handshakes; d_tlast only on the 16th; s_tready=0 afterwards even with s_tvalid=1.
- Drain and done: 15 o_beat without o_last, then o_beat with o_last → done pulses exactly 1 cycle after the last beat; busy is 0 on the following cycle; a start during the frame produces no second config beat.
- Reset mid-frame: resetn low after sample 7 → all outputs 0 asynchronously; a new start then sends a config beat and all 16 samples, with d_tlast on the 16th.
- Back-to-back: start reasserted on the first IDLE cycle → second frame is identical; the counter restarts at 0.

Source files
------------

// File: rtl/fft_frame_sequencer.sv
// ----------------------------------------------------------------------------
// fft_frame_sequencer
//
// Runs one complete FFT transform per accepted start pulse:
//   1. latches {scaleSch, forward} and pushes one config beat to the core,
//   2. gates exactly NFFT samples from the sample source into the core's
//      data-in stream (zero-latency passthrough), flagging the last with TLAST,
//   3. waits for the core's output frame to end (o_beat & o_last),
//   4. pulses done for one cycle and returns to idle.
//
// Ports
//   clk, resetn           clock, asynchronous active-low reset
//   start                 single-cycle run request (honoured only when idle)
//   scaleSch, forward     transform settings, sampled on accepted start
//   busy, done            status: busy from accepted start through done pulse
//   cfg_tvalid/tready/    config stream to the FFT core (one beat per frame)
//   cfg_tdata
//   s_tvalid/tready/      sample source (upstream)
//   s_tdata
//   d_tvalid/tready/      FFT core data-in stream (downstream)
//   d_tdata/tlast
//   o_beat, o_last        observed handshake / tlast of the core's output
// ----------------------------------------------------------------------------
module fft_frame_sequencer #(
   parameter int LOG2_NFFT  = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [3:0]            scaleSch,
   input  logic                  forward,
   output logic                  busy,
   output logic                  done,
   input  logic                  cfg_tready,
   output logic                  cfg_tvalid,
   output logic [7:0]            cfg_tdata,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   input  logic [DATA_WIDTH-1:0] s_tdata,
   output logic                  d_tvalid,
   input  logic                  d_tready,
   output logic [DATA_WIDTH-1:0] d_tdata,
   output logic                  d_tlast,
   input  logic                  o_beat,
   input  logic                  o_last
);

   localparam int                   NFFT     = 1 << LOG2_NFFT;
   localparam logic [LOG2_NFFT-1:0] LAST_IDX = LOG2_NFFT'(NFFT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CONFIG,
      S_STREAM,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t               state_q,      state_d;
   logic [4:0]           cfg_q,        cfg_d;        // {scale, forward}
   logic                 cfg_tvalid_q, cfg_tvalid_d;
   logic [LOG2_NFFT-1:0] count_q,      count_d;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of every other flop, independent of order.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= S_IDLE;
         cfg_q        <= '0;
         cfg_tvalid_q <= 1'b0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         cfg_q        <= cfg_d;
         cfg_tvalid_q <= cfg_tvalid_d;
         count_q      <= count_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   // NOTE: every signal gets a hold-value default up front so no path through
   // the case statement leaves it unassigned (which would infer a latch).
   always_comb begin
      state_d      = state_q;
      cfg_d        = cfg_q;
      cfg_tvalid_d = cfg_tvalid_q;
      count_d      = count_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               cfg_d        = {scaleSch, forward};
               cfg_tvalid_d = 1'b1;
               state_d      = S_CONFIG;
            end
         end
         S_CONFIG: begin
            // cfg_tvalid_q is always set here, so ready alone completes it.
            if (cfg_tready) begin
               cfg_tvalid_d = 1'b0;
               state_d      = S_STREAM;
            end
         end
         S_STREAM: begin
            if (s_tvalid && d_tready) begin
               // Natural wrap returns the counter to 0 after the last sample.
               count_d = count_q + 1'b1;
               if (count_q == LAST_IDX) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Residue o_last seen while streaming never reaches this check.
            if (o_beat && o_last) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   logic stream_active;

   always_comb begin
      stream_active = (state_q == S_STREAM);

      busy       = (state_q != S_IDLE);
      done       = (state_q == S_DONE);
      cfg_tvalid = cfg_tvalid_q;
      cfg_tdata  = {3'b000, cfg_q};

      // Zero-latency passthrough, fully gated off outside the stream phase so
      // the source is never drained and the core never sees stray beats.
      s_tready = stream_active & d_tready;
      d_tvalid = stream_active & s_tvalid;
      d_tdata  = stream_active ? s_tdata : '0;
      d_tlast  = stream_active && (count_q == LAST_IDX);
   end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fft_frame_sequencer
//
// Drives randomized traffic into fft_frame_sequencer and compares each cycle
// against expectations derived from transaction-level bookkeeping kept in the
// bench (samples accepted so far, config beats seen, output beats sent).
// Inputs are driven just after the falling edge; outputs are sampled 1 time
// unit later, well away from the rising edge.
// ----------------------------------------------------------------------------
module tb_fft_frame_sequencer;

   localparam int LOG2_NFFT  = 4;
   localparam int DATA_WIDTH = 32;
   localparam int NFFT       = 1 << LOG2_NFFT;

   logic                  clk;
   logic                  resetn;
   logic                  start;
   logic [3:0]            scaleSch;
   logic                  forward;
   logic                  busy;
   logic                  done;
   logic                  cfg_tready;
   logic                  cfg_tvalid;
   logic [7:0]            cfg_tdata;
   logic                  s_tvalid;
   logic                  s_tready;
   logic [DATA_WIDTH-1:0] s_tdata;
   logic                  d_tvalid;
   logic                  d_tready;
   logic [DATA_WIDTH-1:0] d_tdata;
   logic                  d_tlast;
   logic                  o_beat;
   logic                  o_last;

   int tests_run    = 0;
   int tests_failed = 0;

   fft_frame_sequencer #(
      .LOG2_NFFT (LOG2_NFFT),
      .DATA_WIDTH(DATA_WIDTH)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .start     (start),
      .scaleSch  (scaleSch),
      .forward   (forward),
      .busy      (busy),
      .done      (done),
      .cfg_tready(cfg_tready),
      .cfg_tvalid(cfg_tvalid),
      .cfg_tdata (cfg_tdata),
      .s_tvalid  (s_tvalid),
      .s_tready  (s_tready),
      .s_tdata   (s_tdata),
      .d_tvalid  (d_tvalid),
      .d_tready  (d_tready),
      .d_tdata   (d_tdata),
      .d_tlast   (d_tlast),
      .o_beat    (o_beat),
      .o_last    (o_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Control outputs bundled as {busy, done, cfg_tvalid, s_tready, d_tvalid, d_tlast}
   function automatic logic [5:0] ctrl_obs();
      return {busy, done, cfg_tvalid, s_tready, d_tvalid, d_tlast};
   endfunction

   task automatic drive_quiet();
      start      = 1'b0;
      scaleSch   = 4'h0;
      forward    = 1'b0;
      cfg_tready = 1'b0;
      s_tvalid   = 1'b0;
      s_tdata    = '0;
      d_tready   = 1'b0;
      o_beat     = 1'b0;
      o_last     = 1'b0;
   endtask

   // One full frame. cfg_stall: cycles cfg_tready is held low; n_pre: output
   // beats without o_last before the closing one; abort_at: samples accepted
   // before an asynchronous reset aborts the frame (-1 = run to completion).
   task automatic run_frame(input string tag, input logic [3:0] sch, input logic fwd,
                            input int cfg_stall, input int n_pre, input int abort_at);
      logic [7:0] exp_cfg;
      logic [5:0] obs, expv;
      int         n, cyc, cfg_beats, beats;
      exp_cfg   = {3'b000, sch, fwd};
      cfg_beats = 0;

      // Idle cycle carrying the start request.
      @(negedge clk);
      drive_quiet();
      start = 1'b1; scaleSch = sch; forward = fwd;
      cfg_tready = 1'($urandom_range(0, 1)); s_tvalid = 1'b1; d_tready = 1'b1;
      #1;
      obs = ctrl_obs(); expv = 6'b000000; tests_run++;
      if (obs !== expv) begin
         tests_failed++;
         $display("FAIL %s idle_before_start: got %b want %b", tag, obs, expv);
      end
      @(posedge clk);

      // Config phase: settings inputs scrambled to prove they were latched.
      for (int c = 0; c <= cfg_stall; c++) begin
         @(negedge clk);
         start = 1'($urandom_range(0, 1)); scaleSch = 4'($urandom); forward = 1'($urandom);
         cfg_tready = (c == cfg_stall); s_tvalid = 1'($urandom_range(0, 1)); d_tready = 1'b1;
         #1;
         obs = ctrl_obs(); expv = 6'b101000; tests_run++;
         if (obs !== expv) begin
            tests_failed++;
            $display("FAIL %s config_ctrl c=%0d: got %b want %b", tag, c, obs, expv);
         end
         tests_run++;
         if (cfg_tdata !== exp_cfg) begin
            tests_failed++;
            $display("FAIL %s config_data c=%0d: got %h want %h", tag, c, cfg_tdata, exp_cfg);
         end
         if (cfg_tvalid && cfg_tready) cfg_beats++;
         @(posedge clk);
      end

      // Stream phase with random valid/ready, spurious starts and residue o_last.
      n = 0; cyc = 0;
      while (n < NFFT) begin
         if (cyc >= 400) begin
            tests_run++; tests_failed++;
            $display("FAIL %s stream_timeout: got %0d samples want %0d", tag, n, NFFT);
            break;
         end
         if (n == abort_at) begin
            @(negedge clk);
            s_tvalid = 1'b1; d_tready = 1'b1; s_tdata = $urandom;
            resetn = 1'b0;
            #1;
            obs = ctrl_obs(); expv = 6'b000000; tests_run++;
            if (obs !== expv || cfg_tdata !== 8'h00 || d_tdata !== '0) begin
               tests_failed++;
               $display("FAIL %s async_abort: got ctrl %b cfg %h data %h want all zero",
                        tag, obs, cfg_tdata, d_tdata);
            end
            @(posedge clk);
            @(negedge clk);
            drive_quiet();
            resetn = 1'b1;
            return;
         end
         @(negedge clk);
         start      = 1'($urandom_range(0, 1));
         cfg_tready = 1'($urandom_range(0, 1));
         s_tvalid   = 1'($urandom_range(0, 1));
         d_tready   = ($urandom_range(0, 3) != 0);
         s_tdata    = $urandom;
         o_beat     = ($urandom_range(0, 3) == 0);
         o_last     = 1'($urandom_range(0, 1));
         #1;
         obs = ctrl_obs();
         expv = {1'b1, 1'b0, 1'b0, d_tready, s_tvalid, (n == NFFT - 1)};
         tests_run++;
         if (obs !== expv) begin
            tests_failed++;
            $display("FAIL %s stream_ctrl n=%0d: got %b want %b", tag, n, obs, expv);
         end
         if (s_tvalid && d_tready) begin
            tests_run++;
            if (d_tdata !== s_tdata) begin
               tests_failed++;
               $display("FAIL %s stream_data n=%0d: got %h want %h", tag, n, d_tdata, s_tdata);
            end
            n++;
         end
         cyc++;
         @(posedge clk);
      end

      tests_run++;
      if (cfg_beats != 1) begin
         tests_failed++;
         $display("FAIL %s cfg_beat_count: got %0d want 1", tag, cfg_beats);
      end

      // Drain phase: upstream keeps offering data that must not be taken.
      beats = 0; cyc = 0;
      while (beats <= n_pre && cyc < 400) begin
         @(negedge clk);
         start = 1'($urandom_range(0, 1)); cfg_tready = 1'b1;
         s_tvalid = 1'b1; d_tready = 1'b1; s_tdata = $urandom;
         o_beat = ($urandom_range(0, 2) != 0);
         o_last = o_beat ? (beats == n_pre) : 1'($urandom_range(0, 1));
         #1;
         obs = ctrl_obs(); expv = 6'b100000; tests_run++;
         if (obs !== expv) begin
            tests_failed++;
            $display("FAIL %s drain_ctrl beat=%0d: got %b want %b", tag, beats, obs, expv);
         end
         if (o_beat) beats++;
         cyc++;
         @(posedge clk);
      end

      // Done cycle, one after the closing output beat.
      @(negedge clk);
      o_beat = 1'b0; o_last = 1'b0; start = 1'($urandom_range(0, 1));
      #1;
      obs = ctrl_obs(); expv = 6'b110000; tests_run++;
      if (obs !== expv) begin
         tests_failed++;
         $display("FAIL %s done_pulse: got %b want %b", tag, obs, expv);
      end
      @(posedge clk);
   endtask

   task automatic check_idle(input string tag);
      logic [5:0] obs;
      @(negedge clk);
      drive_quiet();
      s_tvalid = 1'b1; d_tready = 1'b1;
      #1;
      obs = ctrl_obs(); tests_run++;
      if (obs !== 6'b000000) begin
         tests_failed++;
         $display("FAIL %s idle_after_done: got %b want 000000", tag, obs);
      end
      @(posedge clk);
   endtask

   task automatic test_reset();
      logic [5:0] obs;
      drive_quiet();
      resetn = 1'b0;
      s_tvalid = 1'b1; d_tready = 1'b1; s_tdata = 32'hDEAD_BEEF; start = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      obs = ctrl_obs(); tests_run++;
      if (obs !== 6'b000000 || cfg_tdata !== 8'h00 || d_tdata !== '0) begin
         tests_failed++;
         $display("FAIL reset_state: got ctrl %b cfg %h data %h want all zero",
                  obs, cfg_tdata, d_tdata);
      end
      drive_quiet();
      resetn = 1'b1;
      @(posedge clk);
   endtask

   task automatic test_config_no_stall();
      run_frame("cfg_nostall", 4'b1010, 1'b1, 0, 15, -1);
      check_idle("cfg_nostall");
   endtask

   task automatic test_config_stall();
      run_frame("cfg_stall", 4'b0110, 1'b0, 5, 15, -1);
      check_idle("cfg_stall");
   endtask

   task automatic test_random_frames();
      for (int i = 0; i < 6; i++) begin
         run_frame("random", 4'($urandom), 1'($urandom), int'($urandom_range(0, 4)),
                   int'($urandom_range(0, 20)), -1);
         check_idle("random");
      end
   endtask

   task automatic test_reset_mid_frame();
      run_frame("abort", 4'b0011, 1'b1, 1, 15, 7);
      run_frame("after_abort", 4'b1100, 1'b0, 0, 15, -1);
      check_idle("after_abort");
   endtask

   task automatic test_back_to_back();
      run_frame("b2b_first",  4'b1001, 1'b1, 0, 15, -1);
      run_frame("b2b_second", 4'b1001, 1'b1, 0, 15, -1);
      run_frame("b2b_third",  4'b0101, 1'b0, 2, 3, -1);
      check_idle("b2b");
   endtask

   // Everything ready, output closes on its first beat: done lands on the
   // 20th cycle counted from the start cycle (1 + 1 + 16 + 1 + 1).
   task automatic test_min_latency();
      int first_done;
      first_done = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         drive_quiet();
         start = (k == 0); scaleSch = 4'hF; forward = 1'b1;
         cfg_tready = 1'b1; s_tvalid = 1'b1; d_tready = 1'b1; s_tdata = $urandom;
         o_beat = 1'b1; o_last = 1'b1;
         #1;
         if (done && first_done < 0) first_done = k;
         @(posedge clk);
      end
      tests_run++;
      if (first_done != NFFT + 3) begin
         tests_failed++;
         $display("FAIL min_latency: got done at cycle %0d want %0d", first_done, NFFT + 3);
      end
      check_idle("min_latency");
   endtask

   initial begin
      test_reset();
      test_config_no_stall();
      test_config_stall();
      test_random_frames();
      test_reset_mid_frame();
      test_back_to_back();
      test_min_latency();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
